// File: rtl/reset_seq_pkg.sv
// rtl/reset_seq_pkg.sv - shared types and constants for the reset sequencer
package reset_seq_pkg;

  typedef enum logic [1:0] {
    ST_PWRUP,
    ST_RUN,
    ST_SOFT_HOLD,
    ST_ACK
  } seq_state_t;

  localparam int MAX_DOMAINS = 8;
  // Pointer must be able to hold NUM_DOMAINS itself ("all released")
  localparam int IDX_W = $clog2(MAX_DOMAINS + 1);

  // Stage timer width: enough to reach the longer of the two intervals
  function automatic int cnt_w(input int stage_dly, input int soft_hold);
    int m;
    m = (stage_dly > soft_hold) ? stage_dly : soft_hold;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/rst_seq_timer.sv
// rtl/rst_seq_timer.sv - shared stage timer for power-up and soft-hold intervals
module rst_seq_timer #(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic [W-1:0] tgt,
  output logic         done
);

  logic [W-1:0] cnt;

  // Cycles elapsed since the last clear; holds at full scale instead of wrapping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (cnt != {W{1'b1}}) begin
      cnt <= cnt + W'(1);
    end
  end

  // Fires on the edge that completes tgt cycles after the clear
  assign done = (cnt == (tgt - W'(1)));

endmodule

// File: rtl/reset_sequencer.sv
// rtl/reset_sequencer.sv - ordered power-up reset release and soft-reset service
module reset_sequencer
  import reset_seq_pkg::*;
#(
  parameter int NUM_DOMAINS = 4,
  parameter int STAGE_DLY   = 16,
  parameter int SOFT_HOLD   = 8
) (
  input  logic                   clk,
  input  logic                   rstb_h,
  input  logic                   soft_rst_req,
  input  logic [NUM_DOMAINS-1:0] soft_rst_mask,
  output logic [NUM_DOMAINS-1:0] rst_n_out,
  output logic                   por_done,
  output logic                   soft_rst_ack,
  output logic                   busy
);

  localparam int CW = cnt_w(STAGE_DLY, SOFT_HOLD);
  localparam int D  = NUM_DOMAINS;

  seq_state_t       state, state_nxt;
  logic [IDX_W-1:0] idx, idx_nxt;
  logic [D-1:0]     mask_q, mask_nxt;
  logic [D-1:0]     pend, pend_nxt;
  logic [D-1:0]     rst_nxt;
  logic [D-1:0]     low_oh;
  logic             por_nxt, ack_nxt, busy_nxt;
  logic             armed, armed_nxt;
  logic             tmr_clr, tmr_done;
  logic [CW-1:0]    tgt;

  rst_seq_timer #(.W(CW)) u_timer (
    .clk   (clk),
    .rst_n (rstb_h),
    .clr   (tmr_clr),
    .tgt   (tgt),
    .done  (tmr_done)
  );

  // State, pointer, captured mask and registered outputs
  always_ff @(posedge clk or negedge rstb_h) begin
    if (!rstb_h) begin
      state        <= ST_PWRUP;
      idx          <= '0;
      mask_q       <= '0;
      pend         <= '0;
      armed        <= 1'b1;
      rst_n_out    <= '0;
      por_done     <= 1'b0;
      soft_rst_ack <= 1'b0;
      busy         <= 1'b1;
    end else begin
      state        <= state_nxt;
      idx          <= idx_nxt;
      mask_q       <= mask_nxt;
      pend         <= pend_nxt;
      armed        <= armed_nxt;
      rst_n_out    <= rst_nxt;
      por_done     <= por_nxt;
      soft_rst_ack <= ack_nxt;
      busy         <= busy_nxt;
    end
  end

  // Next-state, timer control and next output values
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    mask_nxt  = mask_q;
    pend_nxt  = pend;
    armed_nxt = armed;
    rst_nxt   = rst_n_out;
    por_nxt   = por_done;
    ack_nxt   = 1'b0;
    tmr_clr   = 1'b0;
    // Lowest still-held domain of the captured mask, as a one-hot
    low_oh    = pend & (~pend + D'(1));
    // First soft release waits SOFT_HOLD; every other release waits STAGE_DLY
    tgt       = ((state == ST_SOFT_HOLD) && (pend == mask_q)) ? CW'(SOFT_HOLD) : CW'(STAGE_DLY);

    case (state)
      ST_PWRUP: begin
        if (idx == IDX_W'(D)) begin
          state_nxt = ST_RUN;
          por_nxt   = 1'b1;
        end else if (tmr_done) begin
          rst_nxt = rst_n_out | (D'(1) << idx);
          idx_nxt = idx + IDX_W'(1);
          tmr_clr = 1'b1;
        end
      end
      ST_RUN: begin
        // A held request must drop for one edge before it can trigger again
        if (!soft_rst_req) begin
          armed_nxt = 1'b1;
        end else if (armed) begin
          armed_nxt = 1'b0;
          mask_nxt  = soft_rst_mask;
          pend_nxt  = soft_rst_mask;
          rst_nxt   = rst_n_out & ~soft_rst_mask;
          tmr_clr   = 1'b1;
          state_nxt = ST_SOFT_HOLD;
        end
      end
      ST_SOFT_HOLD: begin
        if (pend == '0) begin
          state_nxt = ST_ACK;
          ack_nxt   = 1'b1;
        end else if (tmr_done) begin
          rst_nxt  = rst_n_out | low_oh;
          pend_nxt = pend & ~low_oh;
          tmr_clr  = 1'b1;
        end
      end
      ST_ACK: begin
        state_nxt = ST_RUN;
      end
      default: begin
        state_nxt = ST_PWRUP;
      end
    endcase

    busy_nxt = (state_nxt != ST_RUN);
  end

endmodule
